// File: rtl/rvm_shift_seq_pkg.sv
// Shared types and constants for the shift sequencer: FSM state encodings
// and the shift op codes used by both the sequencer and its shifter.
package rvm_shift_seq_pkg;

    typedef enum logic [2:0] {
        RVM_SHSEQ_IDLE   = 3'd0,
        RVM_SHSEQ_FETCH1 = 3'd1,
        RVM_SHSEQ_FETCH2 = 3'd2,
        RVM_SHSEQ_EXEC   = 3'd3,
        RVM_SHSEQ_WB     = 3'd4
    } shseq_state_e;

    localparam logic [1:0] RVM_SHIFT_NOP = 2'b00;
    localparam logic [1:0] RVM_SHIFT_SLL = 2'b01;
    localparam logic [1:0] RVM_SHIFT_SRL = 2'b10;
    localparam logic [1:0] RVM_SHIFT_SRA = 2'b11;

endpackage

// File: rtl/rvm_shift_seq_shift.sv
// Combinational 32-bit barrel shifter. The output is zero whenever valid is
// low or the op is NOP; the sequencer handles the move case itself.
module rvm_shift_seq_shift
    import rvm_shift_seq_pkg::*;
(
    input  logic        i_valid,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [4:0]  i_shamt,
    output logic [31:0] o_result
);

    logic signed [31:0] w_sra;

    // Arithmetic right shift kept on a signed wire so the sign bit replicates
    assign w_sra = $signed(i_a) >>> i_shamt;

    // Select the shift flavour for the requested op
    always_comb begin
        o_result = 32'd0;
        if (i_valid) begin
            case (i_op)
                RVM_SHIFT_SLL: o_result = i_a << i_shamt;
                RVM_SHIFT_SRL: o_result = i_a >> i_shamt;
                RVM_SHIFT_SRA: o_result = w_sra;
                default:       o_result = 32'd0;
            endcase
        end else begin
            o_result = 32'd0;
        end
    end

endmodule

// File: rtl/rvm_shift_seq.sv
// Shift sequencer: fetches rs1 (and rs2 for the register form) through the
// single register-file read port, runs the shifter, and writes rd back.
// All outputs are registered: each is computed from the next state so the
// port value lines up with the state the FSM enters on the same edge.
module rvm_shift_seq
    import rvm_shift_seq_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic [1:0]  op,
    input  logic        use_imm,
    input  logic [4:0]  imm,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    input  logic [4:0]  rd_addr,
    output logic        rf_rd_en,
    output logic [4:0]  rf_rd_addr,
    input  logic [31:0] rf_rd_data,
    output logic        rf_wr_en,
    output logic [4:0]  rf_wr_addr,
    output logic [31:0] rf_wr_data
);

    shseq_state_e r_state;
    shseq_state_e w_next_state;

    logic [1:0]  r_op;
    logic        r_use_imm;
    logic [4:0]  r_imm;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic [31:0] r_lhs;

    logic        r_busy;
    logic        r_done;
    logic        r_rd_en;
    logic [4:0]  r_rd_addr;
    logic        r_wr_en;
    logic [4:0]  r_wr_addr;
    logic [31:0] r_result;

    logic        w_busy;
    logic        w_done;
    logic        w_rd_en;
    logic [4:0]  w_rd_addr;
    logic        w_wr_en;
    logic [4:0]  w_wr_addr;
    logic [31:0] w_result;

    logic [4:0]  w_rhs;
    logic        w_shift_valid;
    logic [31:0] w_shift_out;
    logic [31:0] w_exec_result;

    // rs2 data arrives during EXEC, so only bits [4:0] are used as the amount
    assign w_rhs         = r_use_imm ? r_imm : rf_rd_data[4:0];
    assign w_shift_valid = (r_state == RVM_SHSEQ_EXEC) && (r_op != RVM_SHIFT_NOP);
    assign w_exec_result = (r_op == RVM_SHIFT_NOP) ? r_lhs : w_shift_out;

    rvm_shift_seq_shift u_rvm_shift (
        .i_valid  (w_shift_valid),
        .i_op     (r_op),
        .i_a      (r_lhs),
        .i_shamt  (w_rhs),
        .o_result (w_shift_out)
    );

    // Next-state logic and the output values that go with the next state
    always_comb begin
        w_next_state = r_state;
        w_rd_en      = 1'b0;
        w_rd_addr    = 5'd0;
        w_wr_en      = 1'b0;
        w_wr_addr    = 5'd0;
        w_result     = 32'd0;
        w_done       = 1'b0;

        case (r_state)
            RVM_SHSEQ_IDLE: begin
                if (start) begin
                    w_next_state = RVM_SHSEQ_FETCH1;
                end else begin
                    w_next_state = RVM_SHSEQ_IDLE;
                end
            end
            RVM_SHSEQ_FETCH1: w_next_state = RVM_SHSEQ_FETCH2;
            RVM_SHSEQ_FETCH2: w_next_state = RVM_SHSEQ_EXEC;
            RVM_SHSEQ_EXEC:   w_next_state = RVM_SHSEQ_WB;
            RVM_SHSEQ_WB:     w_next_state = RVM_SHSEQ_IDLE;
            default:          w_next_state = RVM_SHSEQ_IDLE;
        endcase

        case (w_next_state)
            RVM_SHSEQ_FETCH1: begin
                // Only reachable from IDLE, where the address is still on the port
                w_rd_en   = 1'b1;
                w_rd_addr = rs1_addr;
            end
            RVM_SHSEQ_FETCH2: begin
                if (r_use_imm) begin
                    w_rd_en   = 1'b0;
                    w_rd_addr = 5'd0;
                end else begin
                    w_rd_en   = 1'b1;
                    w_rd_addr = r_rs2;
                end
            end
            RVM_SHSEQ_WB: begin
                w_done    = 1'b1;
                w_wr_en   = (r_rd != 5'd0);
                w_wr_addr = r_rd;
                w_result  = w_exec_result;
            end
            default: begin
                w_rd_en = 1'b0;
            end
        endcase

        w_busy = (w_next_state != RVM_SHSEQ_IDLE);
    end

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= RVM_SHSEQ_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= 5'd0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= 5'd0;
            r_result  <= 32'd0;
        end else begin
            r_state   <= w_next_state;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_rd_en   <= w_rd_en;
            r_rd_addr <= w_rd_addr;
            r_wr_en   <= w_wr_en;
            r_wr_addr <= w_wr_addr;
            r_result  <= w_result;
        end
    end

    // Instruction fields latched at start, lhs latched from the rs1 read
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_op      <= RVM_SHIFT_NOP;
            r_use_imm <= 1'b0;
            r_imm     <= 5'd0;
            r_rs2     <= 5'd0;
            r_rd      <= 5'd0;
            r_lhs     <= 32'd0;
        end else begin
            if ((r_state == RVM_SHSEQ_IDLE) && start) begin
                r_op      <= op;
                r_use_imm <= use_imm;
                r_imm     <= imm;
                r_rs2     <= rs2_addr;
                r_rd      <= rd_addr;
            end
            if (r_state == RVM_SHSEQ_FETCH2) begin
                r_lhs <= rf_rd_data;
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign rf_rd_en   = r_rd_en;
    assign rf_rd_addr = r_rd_addr;
    assign rf_wr_en   = r_wr_en;
    assign rf_wr_addr = r_wr_addr;
    assign rf_wr_data = r_result;

endmodule

// File: tb/tb_rvm_shift_seq.sv
// Directed bench for rvm_shift_seq with a behavioural one-cycle register file.
module tb_rvm_shift_seq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        busy;
    logic        done;
    logic [1:0]  op;
    logic        use_imm;
    logic [4:0]  imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic        rf_rd_en;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data = 32'd0;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;

    logic [31:0] mem [32];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          overlap_cnt = 0;
    int          n_pass = 0;
    int          n_total = 0;

    typedef struct {
        logic [1:0]  op;
        logic        use_imm;
        logic [4:0]  imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] exp_data;
        logic        exp_wr;
        logic        hold;
    } vec_t;

    vec_t vecs [10];

    rvm_shift_seq dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .op         (op),
        .use_imm    (use_imm),
        .imm        (imm),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rd_addr    (rd_addr),
        .rf_rd_en   (rf_rd_en),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data)
    );

    always #5 clk = ~clk;

    // Register file: read data one cycle after the strobe; counts traffic
    always @(posedge clk) begin
        if (rf_rd_en) begin
            rf_rd_data <= mem[rf_rd_addr];
            rd_cnt     <= rd_cnt + 1;
        end
        if (rf_wr_en) begin
            mem[rf_wr_addr] <= rf_wr_data;
            wr_cnt          <= wr_cnt + 1;
        end
        if (rf_rd_en && rf_wr_en) begin
            overlap_cnt <= overlap_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered at a negedge in IDLE; returns at the negedge of the IDLE cycle after WB
    task automatic run_vec(input vec_t v, input int idx);
        int rd0;
        int wr0;
        rd0      = rd_cnt;
        wr0      = wr_cnt;
        start    = 1'b1;
        op       = v.op;
        use_imm  = v.use_imm;
        imm      = v.imm;
        rs1_addr = v.rs1;
        rs2_addr = v.rs2;
        rd_addr  = v.rd;
        @(negedge clk);
        // FETCH1: scramble the inputs to show the fields were latched
        if (!v.hold) start = 1'b0;
        op       = ~v.op;
        use_imm  = ~v.use_imm;
        imm      = ~v.imm;
        rs1_addr = 5'd30;
        rs2_addr = 5'd30;
        rd_addr  = 5'd30;
        chk($sformatf("v%0d_f1_busy", idx), {31'd0, busy}, 32'd1);
        chk($sformatf("v%0d_f1_rd_en", idx), {31'd0, rf_rd_en}, 32'd1);
        chk($sformatf("v%0d_f1_rd_addr", idx), {27'd0, rf_rd_addr}, {27'd0, v.rs1});
        @(negedge clk);
        // FETCH2
        chk($sformatf("v%0d_f2_rd_en", idx), {31'd0, rf_rd_en}, {31'd0, !v.use_imm});
        if (!v.use_imm) chk($sformatf("v%0d_f2_rd_addr", idx), {27'd0, rf_rd_addr}, {27'd0, v.rs2});
        chk($sformatf("v%0d_f2_wr_en", idx), {31'd0, rf_wr_en}, 32'd0);
        @(negedge clk);
        // EXEC
        if (v.hold) start = 1'b0;
        chk($sformatf("v%0d_ex_busy", idx), {31'd0, busy}, 32'd1);
        chk($sformatf("v%0d_ex_en", idx), {30'd0, rf_rd_en, rf_wr_en}, 32'd0);
        chk($sformatf("v%0d_ex_done", idx), {31'd0, done}, 32'd0);
        @(negedge clk);
        // WB
        chk($sformatf("v%0d_wb_done", idx), {31'd0, done}, 32'd1);
        chk($sformatf("v%0d_wb_wr_en", idx), {31'd0, rf_wr_en}, {31'd0, v.exp_wr});
        chk($sformatf("v%0d_wb_wr_addr", idx), {27'd0, rf_wr_addr}, {27'd0, v.rd});
        chk($sformatf("v%0d_wb_wr_data", idx), rf_wr_data, v.exp_data);
        chk($sformatf("v%0d_wb_rd_en", idx), {31'd0, rf_rd_en}, 32'd0);
        @(negedge clk);
        // IDLE again: nothing restarted, traffic counts as expected
        chk($sformatf("v%0d_idle_busy", idx), {31'd0, busy}, 32'd0);
        chk($sformatf("v%0d_idle_done", idx), {31'd0, done}, 32'd0);
        chk($sformatf("v%0d_reads", idx), rd_cnt - rd0, v.use_imm ? 32'd1 : 32'd2);
        chk($sformatf("v%0d_writes", idx), wr_cnt - wr0, {31'd0, v.exp_wr});
    endtask

    initial begin
        int wr_before;
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        mem[1] = 32'h0000_0001;
        mem[2] = 32'h0000_0005;
        mem[4] = 32'h8000_0000;
        mem[5] = 32'h0000_0021;
        mem[6] = 32'h0000_000F;
        mem[7] = 32'hFFFF_FFFF;
        mem[8] = 32'h0000_0004;

        //          op     imm   amt    rs1    rs2    rd     expected       wr    hold
        vecs[0] = '{2'b01, 1'b0, 5'd0,  5'd1,  5'd2,  5'd3,  32'h0000_0020, 1'b1, 1'b0};
        vecs[1] = '{2'b11, 1'b1, 5'd31, 5'd4,  5'd8,  5'd9,  32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[2] = '{2'b10, 1'b1, 5'd31, 5'd4,  5'd8,  5'd10, 32'h0000_0001, 1'b1, 1'b0};
        vecs[3] = '{2'b01, 1'b0, 5'd0,  5'd6,  5'd5,  5'd11, 32'h0000_001E, 1'b1, 1'b0};
        vecs[4] = '{2'b00, 1'b0, 5'd0,  5'd6,  5'd5,  5'd12, 32'h0000_000F, 1'b1, 1'b0};
        vecs[5] = '{2'b01, 1'b0, 5'd0,  5'd7,  5'd8,  5'd0,  32'hFFFF_FFF0, 1'b0, 1'b0};
        vecs[6] = '{2'b11, 1'b0, 5'd0,  5'd4,  5'd8,  5'd13, 32'hF800_0000, 1'b1, 1'b0};
        vecs[7] = '{2'b10, 1'b0, 5'd0,  5'd7,  5'd8,  5'd14, 32'h0FFF_FFFF, 1'b1, 1'b0};
        vecs[8] = '{2'b01, 1'b0, 5'd0,  5'd1,  5'd1,  5'd1,  32'h0000_0002, 1'b1, 1'b1};
        vecs[9] = '{2'b01, 1'b0, 5'd0,  5'd1,  5'd8,  5'd15, 32'h0000_0020, 1'b1, 1'b0};

        resetn   = 1'b0;
        start    = 1'b0;
        op       = 2'b00;
        use_imm  = 1'b0;
        imm      = 5'd0;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        rd_addr  = 5'd0;

        // Reset held for three cycles, with start asserted to show it is ignored
        start = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rst%0d_ctl", c), {28'd0, busy, done, rf_rd_en, rf_wr_en}, 32'd0);
        end
        chk("rst_addr", {22'd0, rf_rd_addr, rf_wr_addr}, 32'd0);
        chk("rst_data", rf_wr_data, 32'd0);
        start  = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Back-to-back ops from the vector table
        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Abort in FETCH2: no write, no done
        wr_before = wr_cnt;
        start    = 1'b1;
        op       = 2'b01;
        use_imm  = 1'b0;
        rs1_addr = 5'd1;
        rs2_addr = 5'd8;
        rd_addr  = 5'd20;
        @(negedge clk);
        start = 1'b0;
        chk("ab_f1_rd_en", {31'd0, rf_rd_en}, 32'd1);
        @(negedge clk);
        chk("ab_f2_busy", {31'd0, busy}, 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        chk("ab_idle", {28'd0, busy, done, rf_rd_en, rf_wr_en}, 32'd0);
        resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("ab_quiet%0d", c), {28'd0, busy, done, rf_rd_en, rf_wr_en}, 32'd0);
        end
        chk("ab_writes", wr_cnt - wr_before, 32'd0);
        chk("ab_mem20", mem[20], 32'd0);
        chk("rd_wr_overlap", overlap_cnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rvm_shift_seq.md
# rvm_shift_seq

Multi-cycle sequencer that sits directly upstream of the shifter: accepts a decoded shift instruction from the core control FSM and reads rs1 and rs2 from the single-read-port register file. It drives the shifter with registered operands, captures the result and writes it back to rd. It owns the full register-to-register and register-immediate shift path (SLL/SRL/SRA, SLLI/SRLI/SRAI) with a start/done handshake.

## Interface
Parameters: none.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- busy  out  1  high in every state other than IDLE.
- done  out  1  single-cycle pulse in WB.
- op  in  2  shift op: 00 NOP/move, 01 SLL, 10 SRL, 11 SRA (the `RVM_SHIFT_*` codes).
- use_imm  in  1  shift amount comes from imm, not rs2.
- imm  in  5  immediate shift amount.
- rs1_addr, rs2_addr, rd_addr  in  5 each  register indices.
- rf_rd_en  out  1  register-file read strobe.
- rf_rd_addr  out  5  read address.
- rf_rd_data  in  32  read data, valid the cycle after rf_rd_en.
- rf_wr_en  out  1  write strobe.
- rf_wr_addr  out  5  write address.
- rf_wr_data  out  32  write data.

## Operation
- States: IDLE, FETCH1, FETCH2, EXEC, WB.
- IDLE: on start=1, latch op, use_imm, imm, rs1/rs2/rd addresses, then go to FETCH1. start while busy is ignored, with no queueing.
- FETCH1: rf_rd_en=1, rf_rd_addr=rs1. Go to FETCH2.
- FETCH2: latch rf_rd_data as lhs.
  - If !use_imm: rf_rd_en=1, rf_rd_addr=rs2.
  - If use_imm: no read.
  - Go to EXEC.
- EXEC: rhs = use_imm ? imm : rf_rd_data[4:0]; bits [31:5] of rs2 are ignored.
  - Drive the shifter with the latched op.
  - Latch result[31:0] into the result register; result bit 32 is discarded.
  - op=00: shifter stays NOP and the result register takes lhs (register move).
  - Go to WB.
- WB: done=1, rf_wr_addr=rd, rf_wr_data=result, rf_wr_en=(rd_addr!=0). Go to IDLE.
- Shifter valid is not a handshake (combinational). It is asserted in EXEC whenever op!=00.
- Outputs not listed for a state are 0.

## Timing
- Reset: state=IDLE. busy, done, rf_rd_en and rf_wr_en are 0; all address/data outputs are 0; internal latches are cleared.
- Fixed latency: start sampled at edge T gives FETCH1 at T+1, FETCH2 at T+2, EXEC at T+3, WB/done at T+4. This holds for both the immediate and register forms.
- Back-to-back: start may be high in the IDLE cycle right after WB. Throughput is one op per 5 cycles.
- resetn low in any state forces IDLE at the next edge. No rf_wr_en is issued for the aborted op and done does not pulse.
- rs1==rs2: two reads are still issued, with identical results.
- rd==rs1 or rd==rs2: safe, because operands are latched before WB.
- rf_rd_en and rf_wr_en are never high in the same cycle.

## Structure
- State encodings (3-bit) go in rvm_constants.v as `RVM_SHSEQ_*`, alongside the existing `RVM_SHIFT_*` op codes.
- One sub-module: an internal rvm_shift instance fed from the lhs/rhs/op registers.
- All other logic is local: FSM, operand and result registers.

## Test plan
- Reset: hold resetn=0 for 3 cycles → busy=0, done=0, rf_rd_en=0, rf_wr_en=0 throughout.
- SLL register form: x1=0x00000001, x2=0x00000005, op=01, rd=3 → reads of x1 at T+1 and x2 at T+2; at T+4 rf_wr_en=1, addr=3, data=0x00000020, done=1.
- SRAI and SRLI: x4=0x80000000, imm=31.
  - op=11 → writes 0xFFFFFFFF.
  - op=10 → writes 0x00000001.
  - Exactly one read is issued in each case.
- Shift-amount masking and move:
  - x2=0x00000021, x1=0x0000000F, op=01 → writes 0x0000001E.
  - op=00 → writes 0x0000000F unchanged.
- rd=0: SLL, x1=0xFFFFFFFF, x2=0x00000004, rd_addr=0 → done pulses at T+4 with rf_wr_en=0 in all cycles.
- Abort and ignored start:
  - start held high during FETCH1–EXEC → no second op starts before WB.
  - resetn=0 in FETCH2 → IDLE next cycle, no write, no done.
